rr_quantum_arbiter: RTL and testbench
=====================================

Name: rr_quantum_arbiter

Overview:
- Round-robin arbiter with a grant time-slice, sharing one resource between N requesters.
- Successor to the fixed-priority three-way grant FSM; adds fairness, a registered one-hot grant, owner ID and preemption once a slice expires.
- Sits between requesting agents and the shared datapath or bus; the grant vector gates the resource mux.

Parameters:
N  4  number of requesters (2..16)
QUANTUM  8  max consecutive grant cycles before preemption when others wait (>=1)
CW  4  counter width; must satisfy 2^CW > QUANTUM

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
r  input  N  request vector, level; held high while requester wants the resource
g  output  N  grant vector, registered, one-hot or zero
gid  output  $clog2(N)  index of current owner; valid when busy=1, 0 otherwise
busy  output  1  registered; 1 when any grant is active
preempt  output  1  one-cycle pulse in the HANDOFF cycle after a quantum expiry

Behaviour:
- One clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset, sampled on a clk edge: state=IDLE, g=0, gid=0, busy=0, preempt=0, slice counter=0, priority pointer ptr=0.
- rst wins over every other event, including mid-grant; the grant drops on the edge where rst is sampled.
- States: IDLE, GRANT, HANDOFF.
- IDLE:
  - If r!=0, select the first set bit scanning ptr, ptr+1 … N-1, 0 … ptr-1 (wrap-around).
  - At the edge: GRANT, owner k, g=1<<k, gid=k, busy=1, cnt=1, ptr=(k+1) mod N.
  - Latency from request to grant is 1 cycle.
  - If r=0, stay in IDLE; outputs stay 0.
- GRANT (owner k):
  - Release: r[k]=0 -> IDLE. g/busy clear at that edge. ptr is unchanged.
  - Minimum 1 idle cycle between grants; no same-edge regrant.
  - Expiry: r[k]=1, cnt==QUANTUM and (r & ~(1<<k))!=0 -> HANDOFF. g=0, busy=0, preempt=1 for exactly 1 cycle.
  - Saturate: r[k]=1, cnt==QUANTUM and no other request -> stay in GRANT. cnt holds at QUANTUM; no preempt.
    - If another request appears later, expiry fires on the next edge.
  - Otherwise: stay in GRANT, cnt+=1.
  - Release takes precedence over expiry when both hold on the same edge; no preempt pulse in that case.
- HANDOFF: unconditional -> IDLE next edge. preempt=0. Arbitration then uses the updated ptr, so the preempted owner ranks last.
- Invariants checked by the bench:
  - g is one-hot or zero.
  - busy == |g.
  - gid matches the set bit of g.
  - preempt is never high in the same cycle as busy.
  - A requester that is continuously asserted is granted within N*(QUANTUM+2) cycles.
- Requests that drop before they are granted are simply forgotten; there is no request latching.

Test Plan:
- Reset then r=4'b0000 for 5 cycles -> g=0, busy=0, gid=0, preempt=0 throughout.
- r=4'b0101 held, r[0] released after 3 grant cycles -> g=0001 for 3 cycles, 1 idle cycle, g=0100. Then r[2] drops -> IDLE, ptr=3.
- r=4'b1111 held forever, QUANTUM=8 -> grant order 0,1,2,3,0…. Each owner holds 8 cycles, then a HANDOFF cycle with preempt=1, then an idle cycle. Repeat period 40 cycles.
- Only r[1]=1 held for 20 cycles -> g=0010 for all cycles after the first, with no preempt. Assert r[3] at cycle 15 -> HANDOFF on the next edge, then g=1000.
- r[2] falls on the same edge where cnt==QUANTUM with r[0]=1 -> IDLE with preempt=0, then g=0001.
- rst=1 pulsed while g=0100 mid-slice -> g=0 at the next edge. After rst falls with r=4'b0110, the first grant goes to index 1 (ptr reset to 0).

Source files
------------

// File: rtl/rr_quantum_arbiter_if.sv
// Request/grant bundle between the requesting agents and the round-robin
// quantum arbiter. The master side drives requests; the slave side is the
// arbiter that returns grant, owner id, busy and the preemption pulse.
interface rr_quantum_arbiter_if #(
    parameter int N = 4
) ();
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  r;
    logic [N-1:0]  g;
    logic [IW-1:0] gid;
    logic          busy;
    logic          preempt;

    modport master (
        output r,
        input  g,
        input  gid,
        input  busy,
        input  preempt
    );

    modport slave (
        input  r,
        output g,
        output gid,
        output busy,
        output preempt
    );
endinterface

// File: rtl/rr_quantum_arbiter.sv
// Round-robin arbiter with a grant time-slice. One owner at a time holds a
// registered one-hot grant. Once it has held the resource for QUANTUM
// consecutive cycles while somebody else waits, it is preempted through a
// one-cycle HANDOFF state. It then ranks last in the next arbitration.
// CW must be wide enough that QUANTUM fits (2**CW > QUANTUM).
module rr_quantum_arbiter #(
    parameter int N       = 4,
    parameter int QUANTUM = 8,
    parameter int CW      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_quantum_arbiter_if.slave  bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        HANDOFF = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  g_q, g_d;
    logic [IW-1:0] gid_q, gid_d;
    logic          busy_q, busy_d;
    logic          preempt_q, preempt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] ptr_q, ptr_d;

    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] win_next;
    logic [N-1:0]  win_onehot;
    logic [N-1:0]  others;
    logic          owner_req;
    logic          at_quantum;

    // Rotating priority search: first set request starting at ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < N; i++) begin
            int t;
            t = int'(ptr_q) + i;
            if (t >= N) begin
                t = t - N;
            end
            if (!win_found && bus.r[t]) begin
                win_found = 1'b1;
                win_idx   = IW'(t);
            end
        end
    end

    // Pointer moves to the slot just past the new owner.
    assign win_next = (int'(win_idx) == N - 1) ? '0 : win_idx + 1'b1;

    // Decode of the winner and the mask of requesters other than the owner.
    for (genvar gi = 0; gi < N; gi++) begin : g_decode
        assign win_onehot[gi] = (int'(win_idx) == gi);
        assign others[gi]     = bus.r[gi] & ~g_q[gi];
    end

    assign owner_req  = |(bus.r & g_q);
    assign at_quantum = (cnt_q == CW'(QUANTUM));

    // Next-state and next-output computation for the arbiter FSM.
    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        gid_d     = gid_q;
        busy_d    = busy_q;
        preempt_d = 1'b0;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = GRANT;
                    g_d     = win_onehot;
                    gid_d   = win_idx;
                    busy_d  = 1'b1;
                    cnt_d   = CW'(1);
                    ptr_d   = win_next;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    // Voluntary release wins over expiry; no pulse.
                    state_d = IDLE;
                    g_d     = '0;
                    gid_d   = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (at_quantum) begin
                    if (|others) begin
                        state_d   = HANDOFF;
                        g_d       = '0;
                        gid_d     = '0;
                        busy_d    = 1'b0;
                        cnt_d     = '0;
                        preempt_d = 1'b1;
                    end
                    // Nobody waiting: keep the grant, counter saturates.
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HANDOFF: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                g_d     = '0;
                gid_d   = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered outputs; reset overrides everything, mid-grant too.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            g_q       <= '0;
            gid_q     <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
            cnt_q     <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            gid_q     <= gid_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
        end
    end

    assign bus.g       = g_q;
    assign bus.gid     = gid_q;
    assign bus.busy    = busy_q;
    assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_rr_quantum_arbiter.sv
// Scoreboard bench for rr_quantum_arbiter: an independent behavioural model
// pushes the expected outputs for each driven cycle; they are popped and
// compared one cycle-edge later, with invariant and directed checks on top.
module tb_rr_quantum_arbiter;
    localparam int N     = 4;
    localparam int Q     = 8;
    localparam int CW    = 4;
    localparam int LIMIT = N * (Q + 2);

    typedef struct {
        logic [N-1:0] g;
        logic [1:0]   gid;
        logic         busy;
        logic         pre;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rr_quantum_arbiter_if #(.N(N)) bus ();

    rr_quantum_arbiter #(.N(N), .QUANTUM(Q), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state.
    int m_state = 0;   // 0 idle, 1 grant, 2 handoff
    int m_own   = 0;
    int m_cnt   = 0;
    int m_ptr   = 0;
    bit m_pre   = 0;

    // Observed values from the last step.
    logic [N-1:0] o_g;
    logic [1:0]   o_gid;
    logic         o_busy;
    logic         o_pre;
    logic         prev_busy = 1'b0;
    int           cyc = 0;
    int           own_log[$];
    int           start_log[$];
    int           waitc[N];
    int           max_wait = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step(input bit rs, input logic [N-1:0] rv);
        exp_t e;
        int   k;
        if (rs) begin
            m_state = 0; m_own = 0; m_cnt = 0; m_ptr = 0; m_pre = 0;
        end else begin
            case (m_state)
                0: begin
                    m_pre = 0;
                    k = -1;
                    for (int i = 0; i < N; i++) begin
                        int j;
                        j = (m_ptr + i) % N;
                        if (k < 0 && rv[j]) k = j;
                    end
                    if (k >= 0) begin
                        m_state = 1; m_own = k; m_cnt = 1; m_ptr = (k + 1) % N;
                    end
                end
                1: begin
                    m_pre = 0;
                    if (!rv[m_own]) begin
                        m_state = 0;
                    end else if (m_cnt == Q) begin
                        if ((rv & ~(N'(1) << m_own)) != 0) begin
                            m_state = 2; m_pre = 1;
                        end
                    end else begin
                        m_cnt++;
                    end
                end
                default: begin
                    m_state = 0; m_pre = 0;
                end
            endcase
        end
        e.g    = (m_state == 1) ? (N'(1) << m_own) : '0;
        e.gid  = (m_state == 1) ? 2'(m_own) : 2'd0;
        e.busy = (m_state == 1);
        e.pre  = m_pre;
        sb.push_back(e);
    endtask

    // One clock of stimulus: drive, predict, then sample after the edge.
    task automatic step(input bit rs, input logic [N-1:0] rv);
        exp_t e;
        @(negedge clk);
        rst   = rs;
        bus.r = rv;
        model_step(rs, rv);
        @(posedge clk);
        #1;
        cyc++;
        o_g = bus.g; o_gid = bus.gid; o_busy = bus.busy; o_pre = bus.preempt;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("g", 32'(o_g), 32'(e.g));
            check("gid", 32'(o_gid), 32'(e.gid));
            check("busy", 32'(o_busy), 32'(e.busy));
            check("preempt", 32'(o_pre), 32'(e.pre));
        end
        check("inv_onehot", 32'($onehot0(o_g)), 32'd1);
        check("inv_busy", 32'(o_busy), 32'(|o_g));
        check("inv_gid", 32'(o_busy ? o_g[o_gid] : (o_gid == 2'd0)), 32'd1);
        check("inv_pre_busy", 32'(o_pre & o_busy), 32'd0);
        if (o_busy && !prev_busy) begin
            own_log.push_back(int'(o_gid));
            start_log.push_back(cyc);
        end
        prev_busy = o_busy;
        for (int i = 0; i < N; i++) begin
            if (!rs && rv[i] && !o_g[i]) waitc[i]++;
            else waitc[i] = 0;
            if (waitc[i] > max_wait) max_wait = waitc[i];
        end
        $display("cyc=%0d rst=%0b r=%b g=%b gid=%0d busy=%0b preempt=%0b",
                 cyc, rs, rv, o_g, o_gid, o_busy, o_pre);
    endtask

    initial begin
        int npre;
        logic [N-1:0] rr;
        bus.r = '0;
        for (int i = 0; i < N; i++) waitc[i] = 0;

        // Reset and quiet bus.
        step(1'b1, 4'b0000);
        check("rst_g", 32'(o_g), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0000);
        check("idle_busy", 32'(o_busy), 32'd0);

        // Release after 3 cycles, then ptr advances to 3.
        step(1'b0, 4'b0101);
        check("t2_first", 32'(o_g), 32'b0001);
        step(1'b0, 4'b0101);
        step(1'b0, 4'b0101);
        step(1'b0, 4'b0100);
        check("t2_gap", 32'(o_g), 32'd0);
        step(1'b0, 4'b0100);
        check("t2_second", 32'(o_g), 32'b0100);
        step(1'b0, 4'b0100);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b1111);
        check("t2_ptr3", 32'(o_gid), 32'd3);

        // All request: round-robin with 10-cycle slots.
        step(1'b1, 4'b0000);
        own_log.delete(); start_log.delete();
        npre = 0;
        for (int i = 0; i < 90; i++) begin
            step(1'b0, 4'b1111);
            if (o_pre) npre++;
        end
        check("t3_own0", 32'(own_log[0]), 32'd0);
        check("t3_own1", 32'(own_log[1]), 32'd1);
        check("t3_own2", 32'(own_log[2]), 32'd2);
        check("t3_own3", 32'(own_log[3]), 32'd3);
        check("t3_own4", 32'(own_log[4]), 32'd0);
        check("t3_slot", 32'(start_log[1] - start_log[0]), 32'd10);
        check("t3_period", 32'(start_log[4] - start_log[0]), 32'd40);
        check("t3_npre", 32'(npre), 32'd9);

        // Sole requester saturates, then a newcomer causes preemption.
        step(1'b1, 4'b0000);
        npre = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 4'b0010);
            if (o_pre) npre++;
        end
        check("t4_hold", 32'(o_g), 32'b0010);
        check("t4_nopre", 32'(npre), 32'd0);
        step(1'b0, 4'b1010);
        check("t4_pre", 32'(o_pre), 32'd1);
        step(1'b0, 4'b1010);
        step(1'b0, 4'b1010);
        check("t4_next", 32'(o_g), 32'b1000);

        // Release coincident with expiry: no pulse.
        step(1'b1, 4'b0000);
        for (int i = 0; i < 8; i++) step(1'b0, 4'b0100);
        step(1'b0, 4'b0001);
        check("t5_nopre", 32'(o_pre), 32'd0);
        check("t5_idle", 32'(o_busy), 32'd0);
        step(1'b0, 4'b0001);
        check("t5_g", 32'(o_g), 32'b0001);

        // Reset mid-slice.
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0100);
        step(1'b0, 4'b0100);
        check("t6_own", 32'(o_g), 32'b0100);
        step(1'b1, 4'b0100);
        check("t6_rst", 32'(o_g), 32'd0);
        step(1'b0, 4'b0110);
        check("t6_gid", 32'(o_gid), 32'd1);

        // Random traffic with sticky requests and rare resets.
        rr = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) rr[b] = ~rr[b];
            end
            step(($urandom_range(0, 199) == 0), rr);
        end
        check("starve", 32'(max_wait <= LIMIT), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
